// File: rtl/pwm_burst_gen_if.sv
// ============================================================================
// Module      : pwm_burst_gen_if
// Description : Register-side bundle for the PWM/burst generator. Carries the
//               control, period, duty and count words from the register file
//               and returns the status word, PWM pin and done interrupt.
//               master : register-file side (drives the control words)
//               slave  : generator side (drives status, pwm_out, done_irq)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_burst_gen_if #(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 32
);
  logic [31:0]       ctrl_reg;    // [0] enable, [1] start, [2] continuous, [3] clear_flags
  logic [CNT_W-1:0]  period_reg;  // PWM period in clocks
  logic [CNT_W-1:0]  duty_reg;    // high clocks per period
  logic [CNT_W-1:0]  count_reg;   // periods per burst, 0 = unlimited
  logic [STAT_W-1:0] status;      // busy/done/err/state/periods_done
  logic              pwm_out;     // registered PWM pin
  logic              done_irq;    // one-cycle burst-complete pulse

  modport master (
    output ctrl_reg, period_reg, duty_reg, count_reg,
    input  status, pwm_out, done_irq
  );

  modport slave (
    input  ctrl_reg, period_reg, duty_reg, count_reg,
    output status, pwm_out, done_irq
  );
endinterface

`default_nettype wire

// File: rtl/pwm_burst_gen.sv
// ============================================================================
// Module      : pwm_burst_gen
// Description : Register-controlled PWM/burst generator. A rising edge on the
//               start bit (with enable high) launches a burst of PWM periods.
//               Period and duty are shadowed and only reloaded on a period
//               boundary, so register writes never glitch the output.
// Ports       : axi_aclk   - clock, rising edge
//               axi_areset - asynchronous active-high reset
//               bus        - pwm_burst_gen_if.slave (control words in,
//                            status / pwm_out / done_irq out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_burst_gen #(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 32
) (
  input  wire logic       axi_aclk,
  input  wire logic       axi_areset,
  pwm_burst_gen_if.slave  bus
);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_duty_sh;
  logic [CNT_W-1:0] r_count_sh;
  logic [CNT_W-1:0] r_periods_done;
  logic             r_done;
  logic             r_err;
  logic             r_start_q;
  logic             r_pwm;
  logic             r_done_irq;
  logic [STAT_W-1:0] r_status;

  logic             w_enable;
  logic             w_start;
  logic             w_continuous;
  logic             w_clear;
  logic             w_start_edge;
  logic             w_period_ok;
  logic             w_last;
  logic [CNT_W-1:0] w_pd_next;
  logic             w_finish;
  logic [15:0]      w_pd16;
  logic [31:0]      w_status32;
  logic             w_unused_ctrl;

  assign w_enable      = bus.ctrl_reg[0];
  assign w_start       = bus.ctrl_reg[1];
  assign w_continuous  = bus.ctrl_reg[2];
  assign w_clear       = bus.ctrl_reg[3];
  assign w_unused_ctrl = ^bus.ctrl_reg[31:4];

  assign w_start_edge = w_start & ~r_start_q;
  assign w_period_ok  = (bus.period_reg >= CNT_W'(2));
  assign w_last       = (r_cnt == (r_period_sh - CNT_W'(1)));
  assign w_pd_next    = r_periods_done + CNT_W'(1);
  // Burst ends on the boundary that completes the requested period count;
  // a zero count or the continuous bit keeps the burst running.
  assign w_finish     = w_last && !w_continuous && (r_count_sh != '0) &&
                        (w_pd_next == r_count_sh);

  // Status reports only the low 16 bits of the period counter.
  generate
    if (CNT_W >= 16) begin : g_pd_wide
      assign w_pd16 = r_periods_done[15:0];
    end else begin : g_pd_narrow
      assign w_pd16 = {{(16-CNT_W){1'b0}}, r_periods_done};
    end
  endgenerate

  assign w_status32 = {w_pd16, 10'd0, r_state, 1'b0, r_err, r_done,
                       (r_state != C_ST_IDLE)};

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state        <= C_ST_IDLE;
      r_cnt          <= '0;
      r_period_sh    <= '0;
      r_duty_sh      <= '0;
      r_count_sh     <= '0;
      r_periods_done <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_start_q      <= 1'b0;
      r_pwm          <= 1'b0;
      r_done_irq     <= 1'b0;
      r_status       <= '0;
    end else begin
      r_start_q  <= w_start;
      r_done_irq <= 1'b0;

      // Lowest priority: any flag set below overrides this clear.
      if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end

      case (r_state)
        C_ST_IDLE: begin
          if (w_start_edge && w_enable) begin
            if (w_period_ok) begin
              r_period_sh    <= bus.period_reg;
              r_duty_sh      <= bus.duty_reg;
              r_count_sh     <= bus.count_reg;
              r_cnt          <= '0;
              r_periods_done <= '0;
              r_done         <= 1'b0;
              r_err          <= 1'b0;
              r_state        <= C_ST_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        C_ST_RUN: begin
          if (!w_enable) begin
            r_state <= C_ST_IDLE;
          end else if (w_last) begin
            r_cnt          <= '0;
            r_periods_done <= w_pd_next;
            r_duty_sh      <= bus.duty_reg;
            // An illegal period at reload keeps the old shadow.
            if (w_period_ok) begin
              r_period_sh <= bus.period_reg;
            end else begin
              r_err <= 1'b1;
            end
            if (w_finish) begin
              r_state    <= C_ST_DONE;
              r_done     <= 1'b1;
              r_done_irq <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        C_ST_DONE: begin
          r_state <= C_ST_IDLE;
        end

        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase

      r_pwm    <= (r_state == C_ST_RUN) && (r_cnt < r_duty_sh);
      r_status <= STAT_W'(w_status32);
    end
  end

  assign bus.pwm_out  = r_pwm;
  assign bus.done_irq = r_done_irq;
  assign bus.status   = r_status;

endmodule

`default_nettype wire
